// File: rtl/ravan_sha_pkg.sv
// Shared definitions for the sha256 core bus sequencer: register map,
// control/status bit positions, loader state encoding and small helpers.
package ravan_sha_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h10;
  localparam logic [7:0] ADDR_DIGEST0 = 8'h20;

  localparam int CTRL_INIT_BIT    = 0;
  localparam int CTRL_NEXT_BIT    = 1;
  localparam int CTRL_MODE_BIT    = 2;
  localparam int STATUS_READY_BIT = 0;

  localparam logic MODE_SHA256 = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_BLK,
    WRITE_CTRL,
    SETTLE,
    POLL,
    READ_DIG,
    OUT
  } state_t;

  // CTRL word: init starts a new message, next chains onto the current digest.
  function automatic logic [31:0] ctrl_word(input logic first);
    logic [31:0] w;
    w = '0;
    w[CTRL_MODE_BIT] = MODE_SHA256;
    if (first) w[CTRL_INIT_BIT] = 1'b1;
    else       w[CTRL_NEXT_BIT] = 1'b1;
    return w;
  endfunction

  // Word n of a 512-bit block; word 0 sits in the top 32 bits.
  function automatic logic [31:0] word_of(input logic [511:0] blk, input logic [3:0] n);
    return blk[511 - 32*int'(n) -: 32];
  endfunction

endpackage

// File: rtl/sha_block_loader.sv
// Loads one 512-bit block into the sha256 core over its register bus,
// starts init/next, polls for ready, reads back the digest and presents it
// on a valid/ready handshake. All bus outputs come straight from flops.
module sha_block_loader
  import ravan_sha_pkg::*;
#(
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest,
  output logic         err,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data,
  input  logic         core_error
);

  localparam int PW = $clog2(POLL_TIMEOUT + 1);

  state_t         state, state_d;
  logic [3:0]     word_cnt, word_cnt_d, word_nxt;
  logic [PW-1:0]  poll_cnt, poll_cnt_d, poll_inc;
  logic [511:0]   blk_reg;
  logic           first_reg;
  logic           accept, timeout;
  logic           cs_d, we_d;
  logic [7:0]     address_d;
  logic [31:0]    write_data_d;

  assign accept   = (state == IDLE) && blk_valid && blk_ready;
  assign word_nxt = word_cnt + 4'd1;
  assign poll_inc = poll_cnt + 1'b1;

  // Next state, counters and the bus access to present in the next cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_d      = state;
    word_cnt_d   = word_cnt;
    poll_cnt_d   = poll_cnt;
    timeout      = 1'b0;
    cs_d         = 1'b0;
    we_d         = 1'b0;
    address_d    = '0;
    write_data_d = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d      = WRITE_BLK;
          word_cnt_d   = '0;
          poll_cnt_d   = '0;
          cs_d         = 1'b1;
          we_d         = 1'b1;
          address_d    = ADDR_BLOCK0;
          write_data_d = word_of(blk_data, 4'd0);
        end
      end
      WRITE_BLK: begin
        cs_d = 1'b1;
        we_d = 1'b1;
        if (word_cnt == 4'd15) begin
          state_d      = WRITE_CTRL;
          address_d    = ADDR_CTRL;
          write_data_d = ctrl_word(first_reg);
        end else begin
          word_cnt_d   = word_nxt;
          address_d    = ADDR_BLOCK0 + {4'h0, word_nxt};
          write_data_d = word_of(blk_reg, word_nxt);
        end
      end
      WRITE_CTRL: begin
        state_d    = SETTLE;
        word_cnt_d = '0;
      end
      // Two idle bus cycles so the first status read cannot see the ready
      // left over from the previous block.
      SETTLE: begin
        if (word_cnt == 4'd1) begin
          state_d   = POLL;
          cs_d      = 1'b1;
          address_d = ADDR_STATUS;
        end else begin
          word_cnt_d = word_nxt;
        end
      end
      POLL: begin
        if (read_data[STATUS_READY_BIT]) begin
          state_d    = READ_DIG;
          word_cnt_d = '0;
          cs_d       = 1'b1;
          address_d  = ADDR_DIGEST0;
        end else begin
          poll_cnt_d = poll_inc;
          if (poll_inc == PW'(POLL_TIMEOUT)) begin
            state_d = IDLE;
            timeout = 1'b1;
          end else begin
            cs_d      = 1'b1;
            address_d = ADDR_STATUS;
          end
        end
      end
      READ_DIG: begin
        if (word_cnt == 4'd7) begin
          state_d = OUT;
        end else begin
          word_cnt_d = word_nxt;
          cs_d       = 1'b1;
          address_d  = ADDR_DIGEST0 + {4'h0, word_nxt};
        end
      end
      OUT: begin
        if (dig_valid && dig_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, registered bus outputs, handshakes, digest and error flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state      <= IDLE;
      word_cnt   <= '0;
      poll_cnt   <= '0;
      cs         <= 1'b0;
      we         <= 1'b0;
      address    <= '0;
      write_data <= '0;
      blk_ready  <= 1'b0;
      dig_valid  <= 1'b0;
      digest     <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      word_cnt   <= word_cnt_d;
      poll_cnt   <= poll_cnt_d;
      cs         <= cs_d;
      we         <= we_d;
      address    <= address_d;
      write_data <= write_data_d;
      blk_ready  <= (state_d == IDLE);
      dig_valid  <= (state_d == OUT);
      if (state == READ_DIG)
        digest[255 - 32*int'(word_cnt[2:0]) -: 32] <= read_data;
      if (accept)
        err <= 1'b0;
      else if (timeout || (cs && core_error))
        err <= 1'b1;
    end
  end

  // Block capture on the input handshake.
  always_ff @(posedge clk) begin
    // NOTE: the block register is deliberately not reset; it is always
    // loaded before use, and leaving it off the reset net keeps 512 flops
    // free of a reset mux.
    if (accept) begin
      blk_reg   <= blk_data;
      first_reg <= blk_first;
    end
  end

endmodule

// File: tb/tb_sha_block_loader.sv
// Directed bench for sha_block_loader with a behavioural sha256 core model
// (register bus, real compression, configurable ready latency / stuck-busy).
module tb_sha_block_loader;
  import ravan_sha_pkg::*;

  localparam int TB_TIMEOUT = 16;
  localparam int CORE_LAT   = 4;

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] NIST_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] NIST_B2 = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] NIST_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] SHA_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_first = 1'b0;
  logic [511:0] blk_data = '0;
  logic         dig_ready = 1'b0;
  logic         core_error = 1'b0;
  logic         blk_ready, dig_valid, err, cs, we;
  logic [255:0] digest;
  logic [7:0]   address;
  logic [31:0]  write_data, read_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] wr_q [$];

  always #5 clk = ~clk;

  sha_block_loader #(.POLL_TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_first(blk_first),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .digest(digest), .err(err),
    .cs(cs), .we(we), .address(address), .write_data(write_data),
    .read_data(read_data), .core_error(core_error)
  );

  // ---------------- sha256 core model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1, ch, maj;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      ch  = (e & f) ^ (~e & g);
      t1  = h + s1 + ch + K[i] + w[i];
      s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      maj = (a & b) ^ (a & c) ^ (b & c);
      t2  = s0 + maj;
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96]  + e, hin[95:64]   + f, hin[63:32]   + g, hin[31:0]    + h};
  endfunction

  logic [31:0]  core_blk [16];
  logic [255:0] core_h = '0;
  logic         core_ready = 1'b1;
  int           core_busy = 0;
  logic         core_stuck = 1'b0;

  function automatic logic [511:0] pack_blk();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[511 - 32*i -: 32] = core_blk[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (cs && we && address[7:4] == 4'h1) core_blk[address[3:0]] <= write_data;
    if (cs && we && address == ADDR_CTRL) begin
      if (write_data[CTRL_INIT_BIT])      core_h <= sha_compress(SHA_IV, pack_blk());
      else if (write_data[CTRL_NEXT_BIT]) core_h <= sha_compress(core_h, pack_blk());
      core_ready <= 1'b0;
      core_busy  <= CORE_LAT;
    end else if (core_busy != 0) begin
      core_busy <= core_busy - 1;
      if (core_busy == 1) core_ready <= 1'b1;
    end
  end

  always_comb begin
    read_data = '0;
    if (cs && !we) begin
      if (address == ADDR_STATUS)
        read_data = {31'b0, core_ready && !core_stuck};
      else if (address[7:3] == 5'b00100)
        read_data = core_h[255 - 32*int'(address[2:0]) -: 32];
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer a block at the next falling edge; returns just after the accepting edge.
  task automatic accept(input logic [511:0] d, input logic first);
    @(negedge clk);
    check("blk_ready_idle", blk_ready, 1'b1);
    blk_data  = d;
    blk_first = first;
    blk_valid = 1'b1;
    @(posedge clk);
    #1 blk_valid = 1'b0;
  endtask

  // Cycle count from accept (cycle 1 = first after accept) to dig_valid,
  // counting status reads and logging every bus write.
  task automatic wait_digest(output int cyc, output int polls);
    cyc = 0;
    polls = 0;
    wr_q.delete();
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cs && we) wr_q.push_back({address, write_data});
      if (cs && !we && address == ADDR_STATUS) polls++;
      if (dig_valid) break;
    end
    check("dig_valid_seen", dig_valid, 1'b1);
  endtask

  task automatic take_digest();
    dig_ready = 1'b1;
    @(posedge clk);
    #1 dig_ready = 1'b0;
    @(negedge clk);
    check("post_hs_dig_valid", dig_valid, 1'b0);
    check("post_hs_blk_ready", blk_ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc, polls;
    logic [511:0] blk_v;
    logic [255:0] held;
    logic [7:0]   a_exp;
    bit           seen_dv;

    // Reset held 3 cycles: every output zero, then ready one cycle after release.
    repeat (3) @(negedge clk);
    check("rst_blk_ready", blk_ready, 1'b0);
    check("rst_dig_valid", dig_valid, 1'b0);
    check("rst_digest", digest, '0);
    check("rst_err", err, 1'b0);
    check("rst_bus", {cs, we, address, write_data}, '0);
    reset_n = 1'b1;
    @(negedge clk);
    check("release_blk_ready", blk_ready, 1'b1);

    // "abc": bus trace, latency (4-cycle core -> 3 polls -> dig_valid at 31), digest.
    accept(ABC_BLK, 1'b1);
    wait_digest(cyc, polls);
    check("abc_latency", cyc, 31);
    check("abc_polls", polls, 3);
    check("abc_trace_len", wr_q.size(), 17);
    blk_v = ABC_BLK;
    if (wr_q.size() == 17) begin
      for (int i = 0; i < 16; i++) begin
        a_exp = 8'h10 + 8'(i);
        check($sformatf("abc_trace_w%0d", i), wr_q[i], {a_exp, blk_v[511 - 32*i -: 32]});
      end
      check("abc_trace_ctrl", wr_q[16], {8'h08, 32'h5});
    end
    check("abc_digest", digest, ABC_DIG);
    check("abc_err", err, 1'b0);
    take_digest();

    // Two-block NIST message; second block chains with CTRL=0x6 and is backpressured.
    accept(NIST_B1, 1'b1);
    wait_digest(cyc, polls);
    take_digest();
    accept(NIST_B2, 1'b0);
    wait_digest(cyc, polls);
    check("nist_trace_len", wr_q.size(), 17);
    if (wr_q.size() == 17) check("nist_trace_ctrl", wr_q[16], {8'h08, 32'h6});
    check("nist_digest", digest, NIST_DIG);
    held = digest;
    repeat (10) begin
      @(negedge clk);
      check("bp_digest", digest, held);
      check("bp_dig_valid", dig_valid, 1'b1);
      check("bp_blk_ready", blk_ready, 1'b0);
      check("bp_cs", cs, 1'b0);
    end
    take_digest();

    // Timeout: ready never returns -> 16 status reads, err set, back to IDLE at cycle 36.
    core_stuck = 1'b1;
    accept(ABC_BLK, 1'b1);
    cyc = 0;
    polls = 0;
    seen_dv = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cs && !we && address == ADDR_STATUS) polls++;
      if (dig_valid) seen_dv = 1'b1;
      if (blk_ready) break;
    end
    check("to_polls", polls, TB_TIMEOUT);
    check("to_idle_cycle", cyc, 36);
    check("to_err", err, 1'b1);
    check("to_no_digest", seen_dv, 1'b0);
    core_stuck = 1'b0;

    // Next block clears err; a core_error pulse during word 3 sets it again,
    // but the sequence still completes with the right digest.
    accept(ABC_BLK, 1'b1);
    @(negedge clk);
    check("err_cleared", err, 1'b0);
    cyc = 0;
    while (cyc < 20 && !(cs && address == 8'h13)) begin
      @(negedge clk);
      cyc++;
    end
    check("word3_reached", address, 8'h13);
    core_error = 1'b1;
    @(negedge clk);
    core_error = 1'b0;
    wait_digest(cyc, polls);
    check("cerr_digest", digest, ABC_DIG);
    check("cerr_err", err, 1'b1);
    take_digest();

    // Reset during the word-7 write: bus idle next cycle, then a clean "abc".
    accept(ABC_BLK, 1'b1);
    cyc = 0;
    while (cyc < 20 && !(cs && address == 8'h17)) begin
      @(negedge clk);
      cyc++;
    end
    check("word7_reached", address, 8'h17);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_cs", cs, 1'b0);
    check("mid_rst_bus", {we, address, write_data}, '0);
    check("mid_rst_flags", {blk_ready, dig_valid, err}, 3'b000);
    check("mid_rst_digest", digest, '0);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_release_ready", blk_ready, 1'b1);
    accept(ABC_BLK, 1'b1);
    wait_digest(cyc, polls);
    check("after_rst_latency", cyc, 31);
    check("after_rst_digest", digest, ABC_DIG);
    take_digest();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
